// File: rtl/r5p_mouse_trace.sv
// Instruction trace collector for the r5p mouse core: snoops the TCB bus,
// assembles one record per retired instruction and queues it in a small FIFO.
module r5p_mouse_trace #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       pha,
    input  logic             tcb_vld,
    input  logic             tcb_rdy,
    input  logic             tcb_wen,
    input  logic [31:0]      tcb_adr,
    input  logic [1:0]       tcb_siz,
    input  logic             tcb_uns,
    input  logic [31:0]      tcb_wdt,
    input  logic [31:0]      tcb_rdt,
    input  logic             tcb_err,
    output logic             trc_vld,
    input  logic             trc_rdy,
    output logic [31:0]      trc_pc,
    output logic [31:0]      trc_ins,
    output logic             trc_rdv,
    output logic [4:0]       trc_rdi,
    output logic [31:0]      trc_rdd,
    output logic             trc_mev,
    output logic             trc_mew,
    output logic [31:0]      trc_mea,
    output logic [31:0]      trc_med,
    output logic             trc_err,
    output logic             ovf,
    output logic [CNT_W-1:0] drp
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned REC_W = 169;

    localparam logic [2:0] PHA_IF  = 3'b000;
    localparam logic [2:0] PHA_MLD = 3'b001;
    localparam logic [2:0] PHA_MST = 3'b010;
    localparam logic [2:0] PHA_EXE = 3'b011;
    localparam logic [2:0] PHA_WB  = 3'b100;
    localparam logic [2:0] PHA_RS1 = 3'b101;
    localparam logic [2:0] PHA_RS2 = 3'b110;

    logic             d_trn_r;
    logic [2:0]       d_pha_r;
    logic [31:0]      d_adr_r;
    logic             d_wen_r;
    logic [1:0]       d_siz_r;
    logic             d_uns_r;
    logic [31:0]      d_wdt_r;

    logic [31:0]      acc_pc_r;
    logic [31:0]      acc_ins_r;
    logic             acc_rdv_r;
    logic [4:0]       acc_rdi_r;
    logic [31:0]      acc_rdd_r;
    logic             acc_mev_r;
    logic             acc_mew_r;
    logic [31:0]      acc_mea_r;
    logic [31:0]      acc_med_r;
    logic             acc_err_r;

    logic             started_r;
    logic             acc_vld_r;
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic             ovf_r;
    logic [CNT_W-1:0] drp_r;
    logic [REC_W-1:0] mem_r [DEPTH];

    logic             d_if_s;
    logic             push_s;
    logic             pop_s;
    logic             empty_s;
    logic             full_s;
    logic             wr_en_s;
    logic             drop_s;
    logic [REC_W-1:0] acc_rec_s;
    logic [REC_W-1:0] head_s;
    logic             unused_s;

    // Transfer-valid flag of stage D, the only stage-D bit that needs a reset
    always_ff @(posedge clk) begin
        if (rst) begin
            d_trn_r <= 1'b0;
        end else begin
            d_trn_r <= tcb_vld & tcb_rdy;
        end
    end

    // Stage D payload, qualified by d_trn_r downstream
    always_ff @(posedge clk) begin
        d_pha_r <= pha;
        d_adr_r <= tcb_adr;
        d_wen_r <= tcb_wen;
        d_siz_r <= tcb_siz;
        d_uns_r <= tcb_uns;
        d_wdt_r <= tcb_wdt;
    end

    // Phase is already encoded by pha; the write-enable is captured but not needed
    assign unused_s = d_wen_r;

    // FIFO status and push/pop/drop decisions
    always_comb begin
        d_if_s  = d_trn_r & (d_pha_r == PHA_IF);
        empty_s = (wr_ptr_r == rd_ptr_r);
        full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                  (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
        push_s  = d_if_s & acc_vld_r;
        pop_s   = ~empty_s & trc_rdy;
        wr_en_s = push_s & (~full_s | pop_s) & ~rst;
        drop_s  = push_s & full_s & ~pop_s;
    end

    // Accumulator: builds the record of the instruction currently in flight
    always_ff @(posedge clk) begin
        if (d_trn_r) begin
            case (d_pha_r)
                PHA_IF: begin
                    acc_pc_r  <= d_adr_r;
                    acc_ins_r <= tcb_rdt;
                    acc_rdv_r <= 1'b0;
                    acc_mev_r <= 1'b0;
                    acc_err_r <= tcb_err;
                end
                PHA_WB: begin
                    // Only word writes are real GPR writes; anything else targets x0
                    if ({d_uns_r, d_siz_r} == 3'b010) begin
                        acc_rdv_r <= 1'b1;
                        acc_rdi_r <= d_adr_r[6:2];
                        acc_rdd_r <= d_wdt_r;
                    end
                end
                PHA_MLD: begin
                    acc_mev_r <= 1'b1;
                    acc_mew_r <= 1'b0;
                    acc_mea_r <= d_adr_r;
                    acc_med_r <= tcb_rdt;
                    acc_err_r <= acc_err_r | tcb_err;
                end
                PHA_MST: begin
                    acc_mev_r <= 1'b1;
                    acc_mew_r <= 1'b1;
                    acc_mea_r <= d_adr_r;
                    acc_med_r <= d_wdt_r;
                    acc_err_r <= acc_err_r | tcb_err;
                end
                PHA_EXE, PHA_RS1, PHA_RS2: begin
                    acc_err_r <= acc_err_r | tcb_err;
                end
                default: begin
                    acc_err_r <= acc_err_r;
                end
            endcase
        end
    end

    assign acc_rec_s = {acc_pc_r, acc_ins_r, acc_rdv_r, acc_rdi_r, acc_rdd_r,
                        acc_mev_r, acc_mew_r, acc_mea_r, acc_med_r, acc_err_r};

    // Control state; acc_vld_r keeps the reset JAL (first fetched instruction) out of the trace
    always_ff @(posedge clk) begin
        if (rst) begin
            started_r <= 1'b0;
            acc_vld_r <= 1'b0;
            wr_ptr_r  <= {(AW+1){1'b0}};
            rd_ptr_r  <= {(AW+1){1'b0}};
            ovf_r     <= 1'b0;
            drp_r     <= {CNT_W{1'b0}};
        end else begin
            if (d_if_s) begin
                started_r <= 1'b1;
                acc_vld_r <= started_r;
            end
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (drop_s) begin
                ovf_r <= 1'b1;
                if (drp_r != {CNT_W{1'b1}}) begin
                    drp_r <= drp_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    // FIFO storage, deliberately without reset
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= acc_rec_s;
        end
    end

    assign head_s  = mem_r[rd_ptr_r[AW-1:0]];
    assign trc_vld = ~empty_s;
    assign {trc_pc, trc_ins, trc_rdv, trc_rdi, trc_rdd,
            trc_mev, trc_mew, trc_mea, trc_med, trc_err} = head_s;
    assign ovf     = ovf_r;
    assign drp     = drp_r;

endmodule

// File: tb/tb_r5p_mouse_trace.sv
// Directed bench for r5p_mouse_trace: an instruction table with hand-computed
// records, plus sequences for overflow, push/pop at full and mid-instruction reset.
module tb_r5p_mouse_trace;

    localparam int DEPTH = 4;
    localparam int CNT_W = 2;

    localparam logic [2:0] P_IF  = 3'b000;
    localparam logic [2:0] P_MLD = 3'b001;
    localparam logic [2:0] P_MST = 3'b010;
    localparam logic [2:0] P_WB  = 3'b100;
    localparam logic [2:0] P_RS1 = 3'b101;

    logic             clk = 1'b0;
    logic             rst;
    logic [2:0]       pha;
    logic             tcb_vld, tcb_rdy, tcb_wen, tcb_uns, tcb_err;
    logic [31:0]      tcb_adr, tcb_wdt, tcb_rdt;
    logic [1:0]       tcb_siz;
    logic             trc_vld, trc_rdy;
    logic [31:0]      trc_pc, trc_ins, trc_rdd, trc_mea, trc_med;
    logic             trc_rdv, trc_mev, trc_mew, trc_err, ovf;
    logic [4:0]       trc_rdi;
    logic [CNT_W-1:0] drp;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        logic        ie;
        logic        re;
        logic [1:0]  mk;
        logic [31:0] ma;
        logic [31:0] md;
        logic        me;
        logic        wb;
        logic [2:0]  wk;
        logic [4:0]  wrd;
        logic [31:0] wdt;
        logic        e_rdv;
        logic [4:0]  e_rdi;
        logic [31:0] e_rdd;
        logic        e_mev;
        logic        e_mew;
        logic [31:0] e_mea;
        logic [31:0] e_med;
        logic        e_err;
    } vec_t;

    vec_t tab [8];

    r5p_mouse_trace #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .pha(pha),
        .tcb_vld(tcb_vld), .tcb_rdy(tcb_rdy), .tcb_wen(tcb_wen), .tcb_adr(tcb_adr),
        .tcb_siz(tcb_siz), .tcb_uns(tcb_uns), .tcb_wdt(tcb_wdt),
        .tcb_rdt(tcb_rdt), .tcb_err(tcb_err),
        .trc_vld(trc_vld), .trc_rdy(trc_rdy),
        .trc_pc(trc_pc), .trc_ins(trc_ins), .trc_rdv(trc_rdv), .trc_rdi(trc_rdi),
        .trc_rdd(trc_rdd), .trc_mev(trc_mev), .trc_mew(trc_mew), .trc_mea(trc_mea),
        .trc_med(trc_med), .trc_err(trc_err),
        .ovf(ovf), .drp(drp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // One transfer: request cycle, then a cycle carrying the response while a
    // stalled (vld=1, rdy=0) fetch is presented, which must not count as a transfer.
    task automatic xfer(input logic [2:0] p, input logic [31:0] adr, input logic w,
                        input logic [1:0] s, input logic u, input logic [31:0] wd,
                        input logic [31:0] rd, input logic e);
        @(negedge clk);
        pha = p; tcb_vld = 1'b1; tcb_rdy = 1'b1; tcb_wen = w; tcb_adr = adr;
        tcb_siz = s; tcb_uns = u; tcb_wdt = wd; tcb_rdt = 32'h0; tcb_err = 1'b0;
        @(negedge clk);
        pha = P_IF; tcb_vld = 1'b1; tcb_rdy = 1'b0; tcb_adr = 32'hFFFF_FFF0;
        tcb_rdt = rd; tcb_err = e;
    endtask

    task automatic ifetch(input logic [31:0] pc, input logic [31:0] ins, input logic e);
        xfer(P_IF, pc, 1'b0, 2'b10, 1'b0, 32'h0, ins, e);
    endtask

    task automatic body(input vec_t v);
        xfer(P_RS1, 32'h0000_0004, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0000_1234, v.re);
        if (v.mk == 2'd1) xfer(P_MLD, v.ma, 1'b0, 2'b10, 1'b0, 32'h0, v.md, v.me);
        if (v.mk == 2'd2) xfer(P_MST, v.ma, 1'b1, 2'b10, 1'b0, v.md, 32'h0, v.me);
        if (v.wb) xfer(P_WB, {25'h0, v.wrd, 2'b00}, 1'b1, v.wk[1:0], v.wk[2], v.wdt, 32'h0, 1'b0);
    endtask

    task automatic check_rec(input vec_t v);
        chk("rec_vld", {31'h0, trc_vld}, 32'h1);
        chk("rec_pc", trc_pc, v.pc);
        chk("rec_ins", trc_ins, v.ins);
        chk("rec_rdv", {31'h0, trc_rdv}, {31'h0, v.e_rdv});
        chk("rec_mev", {31'h0, trc_mev}, {31'h0, v.e_mev});
        chk("rec_err", {31'h0, trc_err}, {31'h0, v.e_err});
        if (v.e_rdv) begin
            chk("rec_rdi", {27'h0, trc_rdi}, {27'h0, v.e_rdi});
            chk("rec_rdd", trc_rdd, v.e_rdd);
        end
        if (v.e_mev) begin
            chk("rec_mew", {31'h0, trc_mew}, {31'h0, v.e_mew});
            chk("rec_mea", trc_mea, v.e_mea);
            chk("rec_med", trc_med, v.e_med);
        end
    endtask

    initial begin
        logic [31:0] exp_pc  [4];
        logic [4:0]  exp_rdi [4];
        logic [31:0] exp_rdd [4];

        //           pc            ins           ie    re    mk    ma            md            me    wb    wk      wrd    wdt           e_rdv e_rdi  e_rdd         e_mev e_mew e_mea         e_med         e_err
        tab[0] = '{32'h0000_0080, 32'h0050_0093, 1'b0, 1'b0, 2'd0, 32'h0,        32'h0,        1'b0, 1'b1, 3'b010, 5'd1,  32'h0000_0005, 1'b1, 5'd1,  32'h0000_0005, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0};
        tab[1] = '{32'h0000_0100, 32'h0000_2503, 1'b0, 1'b0, 2'd1, 32'h0000_2000, 32'hDEAD_BEEF, 1'b0, 1'b1, 3'b010, 5'd10, 32'hDEAD_BEEF, 1'b1, 5'd10, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0000_2000, 32'hDEAD_BEEF, 1'b0};
        tab[2] = '{32'h0000_0104, 32'h00B1_A223, 1'b0, 1'b0, 2'd2, 32'h0000_3004, 32'h1234_5678, 1'b0, 1'b1, 3'b000, 5'd3,  32'h0000_00AA, 1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 32'h0000_3004, 32'h1234_5678, 1'b0};
        tab[3] = '{32'h0000_0108, 32'h0000_0013, 1'b0, 1'b0, 2'd0, 32'h0,        32'h0,        1'b0, 1'b0, 3'b000, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        1'b0};
        tab[4] = '{32'h0000_010C, 32'h0081_A283, 1'b0, 1'b0, 2'd1, 32'h0000_2008, 32'h0BAD_F00D, 1'b1, 1'b1, 3'b010, 5'd5,  32'h0BAD_F00D, 1'b1, 5'd5,  32'h0BAD_F00D, 1'b1, 1'b0, 32'h0000_2008, 32'h0BAD_F00D, 1'b1};
        tab[5] = '{32'h0000_0110, 32'h0010_8F93, 1'b0, 1'b1, 2'd0, 32'h0,        32'h0,        1'b0, 1'b1, 3'b010, 5'd31, 32'h8000_0001, 1'b1, 5'd31, 32'h8000_0001, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1};
        tab[6] = '{32'h0000_0114, 32'h0000_C303, 1'b0, 1'b0, 2'd0, 32'h0,        32'h0,        1'b0, 1'b1, 3'b110, 5'd6,  32'h0000_0077, 1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        1'b0};
        tab[7] = '{32'h0000_0118, 32'hFFFF_FFFF, 1'b1, 1'b0, 2'd0, 32'h0,        32'h0,        1'b0, 1'b0, 3'b000, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        1'b1};

        exp_pc[0] = 32'h0000_0204; exp_rdi[0] = 5'd1; exp_rdd[0] = 32'd100;
        exp_pc[1] = 32'h0000_0208; exp_rdi[1] = 5'd2; exp_rdd[1] = 32'd101;
        exp_pc[2] = 32'h0000_020C; exp_rdi[2] = 5'd3; exp_rdd[2] = 32'd102;
        exp_pc[3] = 32'h0000_0218; exp_rdi[3] = 5'd6; exp_rdd[3] = 32'd105;

        rst = 1'b1; pha = P_IF; tcb_vld = 1'b0; tcb_rdy = 1'b0; tcb_wen = 1'b0;
        tcb_adr = 32'h0; tcb_siz = 2'b00; tcb_uns = 1'b0; tcb_wdt = 32'h0;
        tcb_rdt = 32'h0; tcb_err = 1'b0; trc_rdy = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_vld", {31'h0, trc_vld}, 32'h0);
        chk("reset_ovf", {31'h0, ovf}, 32'h0);
        chk("reset_drp", {30'h0, drp}, 32'h0);
        rst = 1'b0;

        // Reset JAL at 0x0, then the instruction table; record i appears after IF i+1
        ifetch(32'h0, 32'h0800_006F, 1'b0);
        @(negedge clk);
        chk("jal_if_no_rec", {31'h0, trc_vld}, 32'h0);
        for (int i = 0; i < 8; i++) begin
            ifetch(tab[i].pc, tab[i].ins, tab[i].ie);
            chk("no_bypass", {31'h0, trc_vld}, 32'h0);
            @(negedge clk);
            if (i == 0) chk("jal_suppressed", {31'h0, trc_vld}, 32'h0);
            else        check_rec(tab[i-1]);
            body(tab[i]);
        end
        ifetch(32'h0000_0200, 32'h0000_0013, 1'b0);
        @(negedge clk);
        check_rec(tab[7]);
        @(negedge clk);
        chk("drained", {31'h0, trc_vld}, 32'h0);

        // Six finalised records with the sink stalled: four kept, two dropped
        trc_rdy = 1'b0;
        for (int k = 0; k < 6; k++) begin
            ifetch(32'h0000_0204 + 32'(4*k), 32'h0000_0013, 1'b0);
            xfer(P_WB, 32'(4*(k+1)), 1'b1, 2'b10, 1'b0, 32'(100+k), 32'h0, 1'b0);
        end
        @(negedge clk);
        chk("ovf_set", {31'h0, ovf}, 32'h1);
        chk("drp_two", {30'h0, drp}, 32'h2);
        chk("full_head_pc", trc_pc, 32'h0000_0200);
        repeat (3) @(negedge clk);
        chk("stall_vld", {31'h0, trc_vld}, 32'h1);
        chk("stall_pc", trc_pc, 32'h0000_0200);
        chk("stall_rdv", {31'h0, trc_rdv}, 32'h0);

        // Push and pop in the same cycle while full
        @(negedge clk);
        pha = P_IF; tcb_vld = 1'b1; tcb_rdy = 1'b1; tcb_adr = 32'h0000_021C; tcb_rdt = 32'h0;
        @(negedge clk);
        tcb_rdy = 1'b0; tcb_rdt = 32'h0000_0013; tcb_err = 1'b0; trc_rdy = 1'b1;
        chk("pushpop_head", trc_pc, 32'h0000_0200);
        @(negedge clk);
        chk("pushpop_drp", {30'h0, drp}, 32'h2);
        for (int j = 0; j < 4; j++) begin
            chk("drain_vld", {31'h0, trc_vld}, 32'h1);
            chk("drain_pc", trc_pc, exp_pc[j]);
            chk("drain_rdi", {27'h0, trc_rdi}, {27'h0, exp_rdi[j]});
            chk("drain_rdd", trc_rdd, exp_rdd[j]);
            @(negedge clk);
        end
        chk("occupancy_four", {31'h0, trc_vld}, 32'h0);

        // Reset in the middle of an instruction that already did a load
        ifetch(32'h0000_0300, 32'h0000_0013, 1'b0);
        xfer(P_MLD, 32'h0000_4000, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0000_0055, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_vld", {31'h0, trc_vld}, 32'h0);
        chk("rst_ovf", {31'h0, ovf}, 32'h0);
        chk("rst_drp", {30'h0, drp}, 32'h0);
        ifetch(32'h0000_0400, 32'h0000_0013, 1'b0);
        @(negedge clk);
        chk("rst_first_if", {31'h0, trc_vld}, 32'h0);
        xfer(P_WB, 32'h0000_001C, 1'b1, 2'b10, 1'b0, 32'h0000_0077, 32'h0, 1'b0);
        ifetch(32'h0000_0404, 32'h0070_0393, 1'b0);
        @(negedge clk);
        chk("rst_second_if", {31'h0, trc_vld}, 32'h0);
        xfer(P_WB, 32'h0000_0020, 1'b1, 2'b10, 1'b0, 32'h0000_0088, 32'h0, 1'b0);
        ifetch(32'h0000_0408, 32'h0000_0013, 1'b0);
        @(negedge clk);
        chk("post_rst_vld", {31'h0, trc_vld}, 32'h1);
        chk("post_rst_pc", trc_pc, 32'h0000_0404);
        chk("post_rst_rdi", {27'h0, trc_rdi}, 32'd8);
        chk("post_rst_rdd", trc_rdd, 32'h0000_0088);
        chk("post_rst_mev", {31'h0, trc_mev}, 32'h0);

        // Four drops into a 2-bit counter: it must stick at all-ones
        @(negedge clk);
        trc_rdy = 1'b0;
        for (int k = 0; k < 8; k++) begin
            ifetch(32'h0000_0500 + 32'(4*k), 32'h0000_0013, 1'b0);
        end
        @(negedge clk);
        chk("drp_saturated", {30'h0, drp}, 32'h3);
        chk("sat_ovf", {31'h0, ovf}, 32'h1);
        chk("sat_head_pc", trc_pc, 32'h0000_0408);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
